// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: datapath width and immediate-format encodings.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01
    } imm_src_e;

endpackage

// File: rtl/sign_extend_imm_decode.sv
// Combinational immediate extraction and sign extension for I- and S-type instructions.
module imm_decode
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] In,
    input  logic [1:0]      ImmSrc,
    output logic [XLEN-1:0] imm_n
);

    // Opcode and rs1/funct3 fields never contribute to an I/S immediate.
    logic unused_fields;
    assign unused_fields = ^{In[19:12], In[6:0]};

    always_comb begin
        imm_n = '0;
        case (ImmSrc)
            IMM_I:   imm_n = {{20{In[31]}}, In[31:20]};
            IMM_S:   imm_n = {{20{In[31]}}, In[31:25], In[11:7]};
            default: imm_n = '0;
        endcase
    end

endmodule

// File: rtl/sign_extend.sv
// RV32I immediate generator: decodes the immediate and registers it for the execute stage.
module sign_extend
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] In,
    input  logic [1:0]      ImmSrc,
    output logic [XLEN-1:0] Imm_Ext
);

    logic [XLEN-1:0] imm_n;

    imm_decode u_imm_decode (
        .In     (In),
        .ImmSrc (ImmSrc),
        .imm_n  (imm_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Imm_Ext <= '0;
        end else begin
            Imm_Ext <= imm_n;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: vector table plus latency and async-reset sequences.
module tb_sign_extend;

    logic        clk;
    logic        rst;
    logic [31:0] In;
    logic [1:0]  ImmSrc;
    logic [31:0] Imm_Ext;

    int unsigned total;
    int unsigned passed;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [1:0]  src;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    sign_extend dut (
        .clk     (clk),
        .rst     (rst),
        .In      (In),
        .ImmSrc  (ImmSrc),
        .Imm_Ext (Imm_Ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;

        vecs[0]  = '{"addi_pos",       32'h0050_0313, 2'b00, 32'h0000_0005};
        vecs[1]  = '{"sw_pos",         32'h0064_A423, 2'b01, 32'h0000_0008};
        vecs[2]  = '{"i_neg1",         32'hFFF0_0093, 2'b00, 32'hFFFF_FFFF};
        vecs[3]  = '{"s_neg4",         32'hFE11_2E23, 2'b01, 32'hFFFF_FFFC};
        vecs[4]  = '{"rsvd_10",        32'h0064_A423, 2'b10, 32'h0000_0000};
        vecs[5]  = '{"rsvd_11",        32'h0064_A423, 2'b11, 32'h0000_0000};
        vecs[6]  = '{"i_max_pos",      32'h7FF0_0013, 2'b00, 32'h0000_07FF};
        vecs[7]  = '{"i_min_neg",      32'h8000_0013, 2'b00, 32'hFFFF_F800};
        vecs[8]  = '{"s_min_neg",      32'h8000_0013, 2'b01, 32'hFFFF_F800};
        vecs[9]  = '{"s_low_field",    32'h0000_0F80, 2'b01, 32'h0000_001F};
        vecs[10] = '{"i_ignores_low",  32'h0000_0F80, 2'b00, 32'h0000_0000};
        vecs[11] = '{"opcode_ignored", 32'h0050_007F, 2'b00, 32'h0000_0005};

        rst    = 1'b1;
        In     = 32'hDEAD_BEEF;
        ImmSrc = 2'b00;
        #1 check("reset_no_edge", Imm_Ext, 32'h0);
        @(posedge clk); #1 check("reset_hold_edge", Imm_Ext, 32'h0);

        @(negedge clk);
        rst    = 1'b0;
        In     = 32'h0050_0313;
        ImmSrc = 2'b00;
        #1 check("release_hold", Imm_Ext, 32'h0);
        @(posedge clk); #1 check("first_edge_load", Imm_Ext, 32'h0000_0005);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            In     = vecs[i].instr;
            ImmSrc = vecs[i].src;
            @(posedge clk); #1 check(vecs[i].name, Imm_Ext, vecs[i].exp);
        end

        // Latency: mid-cycle input change must not reach the output before the next edge.
        @(negedge clk);
        In     = 32'h7FF0_0013;
        ImmSrc = 2'b00;
        @(posedge clk); #1 check("lat_load", Imm_Ext, 32'h0000_07FF);
        #1 In = 32'hFFF0_0093;
        #1 check("lat_hold_mid", Imm_Ext, 32'h0000_07FF);
        @(negedge clk); check("lat_hold_neg", Imm_Ext, 32'h0000_07FF);
        @(posedge clk); #1 check("lat_update", Imm_Ext, 32'hFFFF_FFFF);

        // Async reset mid-cycle, then release and reload.
        #2 rst = 1'b1;
        #1 check("async_clear", Imm_Ext, 32'h0);
        @(posedge clk); #1 check("async_hold_edge", Imm_Ext, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        In     = 32'h0064_A423;
        ImmSrc = 2'b01;
        #1 check("async_release_hold", Imm_Ext, 32'h0);
        @(posedge clk); #1 check("async_first_load", Imm_Ext, 32'h0000_0008);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
